// File: rtl/spi_fb_pkg.sv
// -----------------------------------------------------------------------------
// spi_fb_pkg
// Shared constants and types for the SPI framebuffer writer.
//   CMD_WRITE            header command byte that opens a pixel write stream
//   SYNC_STAGES_DEFAULT  synchronizer depth used when the top is not overridden
//   LINE_*               bit positions of the SPI lines in the synchronizer bus
//   fb_state_t           header/stream decoder state encoding
// -----------------------------------------------------------------------------
package spi_fb_pkg;

    localparam logic [7:0] CMD_WRITE           = 8'h01;
    localparam int         SYNC_STAGES_DEFAULT = 2;

    // Order of the SPI lines inside the 3-bit synchronizer vector.
    localparam int LINE_SCLK = 0;
    localparam int LINE_MOSI = 1;
    localparam int LINE_SS   = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR_HI = 3'd2,
        ADDR_LO = 3'd3,
        DATA    = 3'd4,
        DISCARD = 3'd5
    } fb_state_t;

endpackage

// File: rtl/spi_fb_writer_if.sv
// -----------------------------------------------------------------------------
// spi_fb_writer_if
// Bundles the SPI slave pins and the framebuffer write port of spi_fb_writer.
//   spi_sclk_i / spi_mosi_i / spi_ss_i   SPI mode 0 lines from the host MCU
//   fb_we_o / fb_addr_o / fb_data_o      framebuffer write strobe, address, pixel
//   frame_done_o                         pulse: transaction ended after >=1 pixel
//   cmd_err_o                            pulse: unknown command byte received
// Modports:
//   master  host side (drives SPI, observes framebuffer port)
//   slave   writer side (samples SPI, drives framebuffer port)
// -----------------------------------------------------------------------------
interface spi_fb_writer_if #(
    parameter int ADDR_W  = 16,
    parameter int PIXEL_W = 8
) ();

    logic               spi_sclk_i;
    logic               spi_mosi_i;
    logic               spi_ss_i;

    logic               fb_we_o;
    logic [ADDR_W-1:0]  fb_addr_o;
    logic [PIXEL_W-1:0] fb_data_o;
    logic               frame_done_o;
    logic               cmd_err_o;

    modport master (
        output spi_sclk_i,
        output spi_mosi_i,
        output spi_ss_i,
        input  fb_we_o,
        input  fb_addr_o,
        input  fb_data_o,
        input  frame_done_o,
        input  cmd_err_o
    );

    modport slave (
        input  spi_sclk_i,
        input  spi_mosi_i,
        input  spi_ss_i,
        output fb_we_o,
        output fb_addr_o,
        output fb_data_o,
        output frame_done_o,
        output cmd_err_o
    );

endinterface

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Multi-bit input synchronizer with edge detection. Every bit runs through the
// same number of flops so related lines (SCLK/MOSI/SS) stay aligned with each
// other after synchronization.
//   clk_i    sampling clock
//   rst_i    asynchronous, active-high reset (all flops to 0)
//   d_i      raw asynchronous inputs
//   q_o      synchronized inputs
//   rise_o   per-bit 0->1 transition of q_o (combinational, 1 cycle wide)
//   fall_o   per-bit 1->0 transition of q_o (combinational, 1 cycle wide)
// -----------------------------------------------------------------------------
module spi_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Stage 0 is the first flop after the pin; stage STAGES-1 is the output.
    logic [STAGES-1:0][WIDTH-1:0] stage_reg;
    logic [WIDTH-1:0]             prev_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_reg <= '0;
            prev_reg  <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d_i};
            prev_reg  <= stage_reg[STAGES-1];
        end
    end

    assign q_o    = stage_reg[STAGES-1];
    assign rise_o = q_o & ~prev_reg;
    assign fall_o = ~q_o & prev_reg;

endmodule

// File: rtl/spi_fb_writer.sv
// -----------------------------------------------------------------------------
// spi_fb_writer
// SPI mode 0 slave that receives a command/address header followed by a pixel
// stream and writes each pixel into the framebuffer at auto-incrementing
// addresses. SCLK/MOSI/SS are oversampled with clk_i.
//   Frame: byte0 = command (0x01 = write), byte1 = addr[15:8], byte2 = addr[7:0],
//          byte3.. = RGB332 pixels.
// Ports:
//   clk_i   pixel clock (SPI clock must be <= clk_i/4)
//   rst_i   asynchronous, active-high reset
//   bus     spi_fb_writer_if.slave: SPI inputs, framebuffer write port,
//           frame_done_o and cmd_err_o status pulses
// Write latency: SYNC_STAGES+2 clk_i cycles from the raw SCLK edge of the LSB
// to fb_we_o.
// -----------------------------------------------------------------------------
module spi_fb_writer
    import spi_fb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int PIXEL_W     = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    spi_fb_writer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic [2:0] raw_lines;
    logic [2:0] sync_lines;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    assign raw_lines[LINE_SCLK] = bus.spi_sclk_i;
    assign raw_lines[LINE_MOSI] = bus.spi_mosi_i;
    assign raw_lines[LINE_SS]   = bus.spi_ss_i;

    spi_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (raw_lines),
        .q_o    (sync_lines),
        .rise_o (sync_rise),
        .fall_o (sync_fall)
    );

    logic sync_ss;
    logic sync_mosi;
    logic sclk_rise;
    logic ss_rise;

    assign sync_ss   = sync_lines[LINE_SS];
    assign sync_mosi = sync_lines[LINE_MOSI];
    assign sclk_rise = sync_rise[LINE_SCLK];
    assign ss_rise   = sync_rise[LINE_SS];

    // Only SCLK/SS rising edges and the MOSI/SS levels drive the decoder.
    logic unused_edges;
    assign unused_edges = ^{sync_lines[LINE_SCLK], sync_rise[LINE_MOSI], sync_fall};

    // ------------------------------------------------------------------
    // Byte assembler
    // ------------------------------------------------------------------
    // shreg_reg holds the complete byte during the byte_valid_reg cycle; the
    // next SCLK edge is at least 4 clk_i cycles away, so no separate byte
    // register is needed.
    logic [7:0] shreg_reg;
    logic [2:0] bit_cnt_reg;
    logic       byte_valid_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_reg      <= '0;
            bit_cnt_reg    <= '0;
            byte_valid_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (sync_ss) begin
                // Deselected: drop any partial byte, including an edge that
                // coincides with SS rising.
                shreg_reg   <= '0;
                bit_cnt_reg <= '0;
            end else if (sclk_rise) begin
                shreg_reg      <= {shreg_reg[6:0], sync_mosi};
                bit_cnt_reg    <= bit_cnt_reg + 3'd1;
                byte_valid_reg <= (bit_cnt_reg == 3'd7);
            end
        end
    end

    // ------------------------------------------------------------------
    // Header decoder, address counter and output registers
    // ------------------------------------------------------------------
    fb_state_t         state_reg;
    logic [7:0]        addr_hi_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              pix_written_reg;
    logic [15:0]       header_addr;

    // Narrow framebuffers keep the low bits of the 16-bit header address.
    assign header_addr = {addr_hi_reg, shreg_reg};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg        <= IDLE;
            addr_hi_reg      <= '0;
            addr_reg         <= '0;
            pix_written_reg  <= 1'b0;
            bus.fb_we_o      <= 1'b0;
            bus.fb_addr_o    <= '0;
            bus.fb_data_o    <= '0;
            bus.frame_done_o <= 1'b0;
            bus.cmd_err_o    <= 1'b0;
        end else begin
            bus.fb_we_o      <= 1'b0;
            bus.frame_done_o <= 1'b0;
            bus.cmd_err_o    <= 1'b0;

            // Advance one cycle after each write; wraps naturally at ADDR_W.
            if (bus.fb_we_o) begin
                addr_reg <= addr_reg + ADDR_ONE;
            end

            if (state_reg == IDLE) begin
                pix_written_reg <= 1'b0;
            end

            if (sync_ss) begin
                state_reg        <= IDLE;
                bus.frame_done_o <= ss_rise & pix_written_reg;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        state_reg <= CMD;
                    end
                    CMD: begin
                        if (byte_valid_reg) begin
                            if (shreg_reg == CMD_WRITE) begin
                                state_reg <= ADDR_HI;
                            end else begin
                                state_reg     <= DISCARD;
                                bus.cmd_err_o <= 1'b1;
                            end
                        end
                    end
                    ADDR_HI: begin
                        if (byte_valid_reg) begin
                            addr_hi_reg <= shreg_reg;
                            state_reg   <= ADDR_LO;
                        end
                    end
                    ADDR_LO: begin
                        if (byte_valid_reg) begin
                            addr_reg  <= header_addr[ADDR_W-1:0];
                            state_reg <= DATA;
                        end
                    end
                    DATA: begin
                        if (byte_valid_reg) begin
                            bus.fb_we_o     <= 1'b1;
                            bus.fb_addr_o   <= addr_reg;
                            bus.fb_data_o   <= shreg_reg[PIXEL_W-1:0];
                            pix_written_reg <= 1'b1;
                        end
                    end
                    DISCARD: begin
                        // Swallow bytes until the host deselects.
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_spi_fb_writer
// Directed bench for spi_fb_writer: drives SPI frames bit by bit, captures
// framebuffer writes and status pulses on the falling clock edge, and compares
// them with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_spi_fb_writer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_fb_writer_if #(.ADDR_W(16), .PIXEL_W(8)) bus ();

    spi_fb_writer #(
        .ADDR_W      (16),
        .PIXEL_W     (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          last_edge_cyc = 0;
    logic [23:0] wr_q[$];
    int          lat_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          dup_cnt = 0;
    logic        we_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fb_we_o === 1'b1) begin
            wr_q.push_back({bus.fb_addr_o, bus.fb_data_o});
            lat_q.push_back(cyc - last_edge_cyc);
            if (we_prev) dup_cnt++;
        end
        we_prev = (bus.fb_we_o === 1'b1);
        if (bus.frame_done_o === 1'b1) done_cnt++;
        if (bus.cmd_err_o === 1'b1) err_cnt++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [7:0]  tx_q[$];
    logic [23:0] exp_q[$];

    task automatic clear_mon();
        wr_q.delete();
        lat_q.delete();
        exp_q.delete();
        tx_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        dup_cnt  = 0;
    endtask

    // Shift out the nbits most significant bits of b, MSB first.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input int div);
        for (int k = 0; k < nbits; k++) begin
            bus.spi_mosi_i = b[7-k];
            bus.spi_sclk_i = 1'b0;
            repeat (div / 2) @(negedge clk);
            bus.spi_sclk_i = 1'b1;
            if (k == 7) last_edge_cyc = cyc;
            repeat (div / 2) @(negedge clk);
        end
        bus.spi_sclk_i = 1'b0;
    endtask

    task automatic ss_low();
        bus.spi_ss_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        bus.spi_sclk_i = 1'b0;
        repeat (6) @(negedge clk);
        bus.spi_ss_i = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_tx(input int div);
        foreach (tx_q[i]) spi_bits(tx_q[i], 8, div);
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, " write count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check_eq($sformatf("%s write %0d addr/data", tag, i), wr_q[i], exp_q[i]);
        check_eq({tag, " back-to-back strobes"}, dup_cnt, 0);
    endtask

    task automatic report(input string tag);
        $display("frame %-12s writes=%0d frame_done=%0d cmd_err=%0d", tag, wr_q.size(), done_cnt, err_cnt);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst            = 1'b1;
        bus.spi_sclk_i = 1'b0;
        bus.spi_mosi_i = 1'b0;
        bus.spi_ss_i   = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("reset fb_we_o",      bus.fb_we_o,      1'b0);
        check_eq("reset fb_addr_o",    bus.fb_addr_o,    16'h0);
        check_eq("reset fb_data_o",    bus.fb_data_o,    8'h0);
        check_eq("reset frame_done_o", bus.frame_done_o, 1'b0);
        check_eq("reset cmd_err_o",    bus.cmd_err_o,    1'b0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single pixel, leaves non-zero values held on the write port.
        clear_mon();
        tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h20); tx_q.push_back(8'h5A);
        exp_q.push_back(24'h00205A);
        ss_low(); send_tx(4); ss_high();
        report("single");
        check_writes("single");
        check_eq("single frame_done", done_cnt, 1);
        check_eq("single held addr", bus.fb_addr_o, 16'h0020);
        check_eq("single held data", bus.fb_data_o, 8'h5A);

        // Asynchronous reset after two header bytes.
        clear_mon();
        ss_low();
        spi_bits(8'h01, 8, 4);
        spi_bits(8'h00, 8, 4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async rst fb_addr_o", bus.fb_addr_o, 16'h0);
        check_eq("async rst fb_data_o", bus.fb_data_o, 8'h0);
        check_eq("async rst fb_we_o",   bus.fb_we_o,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        ss_high();
        report("reset-mid");
        check_eq("reset-mid writes", wr_q.size(), 0);
        check_eq("reset-mid frame_done", done_cnt, 0);

        clear_mon();
        tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h05); tx_q.push_back(8'h7E);
        exp_q.push_back(24'h00057E);
        ss_low(); send_tx(4); ss_high();
        report("after-reset");
        check_writes("after-reset");
        check_eq("after-reset frame_done", done_cnt, 1);
        check_eq("write latency cycles", (lat_q.size() > 0) ? lat_q[0] : -1, 4);

        // Three pixels at clk/4.
        clear_mon();
        tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h10);
        tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC);
        exp_q.push_back(24'h0010AA); exp_q.push_back(24'h0011BB); exp_q.push_back(24'h0012CC);
        ss_low(); send_tx(4); ss_high();
        report("three");
        check_writes("three");
        check_eq("three frame_done", done_cnt, 1);
        check_eq("three cmd_err", err_cnt, 0);
        check_eq("three held addr", bus.fb_addr_o, 16'h0012);
        check_eq("three held data", bus.fb_data_o, 8'hCC);

        // Address wrap.
        clear_mon();
        tx_q.push_back(8'h01); tx_q.push_back(8'hFF); tx_q.push_back(8'hFF);
        tx_q.push_back(8'h11); tx_q.push_back(8'h22);
        exp_q.push_back(24'hFFFF11); exp_q.push_back(24'h000022);
        ss_low(); send_tx(4); ss_high();
        report("wrap");
        check_writes("wrap");
        check_eq("wrap frame_done", done_cnt, 1);

        // Unknown command.
        clear_mon();
        tx_q.push_back(8'h55); tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
        ss_low(); send_tx(4); ss_high();
        report("bad-cmd");
        check_eq("bad-cmd cmd_err pulses", err_cnt, 1);
        check_eq("bad-cmd writes", wr_q.size(), 0);
        check_eq("bad-cmd frame_done", done_cnt, 0);

        // Partial trailing byte is dropped.
        clear_mon();
        tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'hAA);
        exp_q.push_back(24'h0000AA);
        ss_low(); send_tx(4); spi_bits(8'hF0, 5, 4); ss_high();
        report("partial");
        check_writes("partial");
        check_eq("partial frame_done", done_cnt, 1);

        clear_mon();
        tx_q.push_back(8'h01); tx_q.push_back(8'h00); tx_q.push_back(8'h30); tx_q.push_back(8'h99);
        exp_q.push_back(24'h003099);
        ss_low(); send_tx(4); ss_high();
        report("post-partial");
        check_writes("post-partial");
        check_eq("post-partial frame_done", done_cnt, 1);
        check_eq("post-partial cmd_err", err_cnt, 0);

        // Long random streams at clk/4 and clk/8.
        for (int d = 4; d <= 8; d += 4) begin
            logic [7:0] px;
            clear_mon();
            tx_q.push_back(8'h01); tx_q.push_back(8'h12); tx_q.push_back(8'h34);
            for (int i = 0; i < 256; i++) begin
                px = 8'($urandom_range(0, 255));
                tx_q.push_back(px);
                exp_q.push_back({16'h1234 + 16'(i), px});
            end
            ss_low(); send_tx(d); ss_high();
            report($sformatf("random/%0d", d));
            check_writes($sformatf("random/%0d", d));
            check_eq($sformatf("random/%0d frame_done", d), done_cnt, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
